// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive front-end.
// PS2_BREAK_DECODE_EN widens the queued word to {extended, break, code}.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  localparam int PS2_FILTER_LEN_DEF     = 4;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 50000;
  localparam int PS2_FIFO_DEPTH_DEF     = 4;

`ifdef PS2_BREAK_DECODE_EN
  localparam int PS2_DATA_W = 10;
`else
  localparam int PS2_DATA_W = 8;
`endif

  typedef logic [PS2_DATA_W-1:0] ps2_word_t;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser, run-length glitch filter and falling-edge strobe
// for the PS/2 clock pin. Reset presets everything to the idle-high bus level.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with a show-ahead scancode FIFO.
// Optional PS2_BREAK_DECODE_EN folds E0/F0 prefixes into flag bits of the next code.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF,
  parameter int FIFO_DEPTH     = PS2_FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [PS2_DATA_W-1:0] rd_data,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic       strobe;
  logic [1:0] dat_sync_q;
  logic       dat;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (ps2_clk),
    .fall_o (strobe)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dat_sync_q <= 2'b11;
    else          dat_sync_q <= {dat_sync_q[0], ps2_dat};
  end

  assign dat = dat_sync_q[1];

  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        push_q, push_d;
  ps2_word_t   push_data_q, push_data_d;
  logic        timeout, frame_bad;

`ifdef PS2_BREAK_DECODE_EN
  logic ext_q, ext_d, brk_q, brk_d;
`endif

  // Frame deserialiser; the timeout only runs while a frame is in flight.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    timeout     = 1'b0;
    frame_bad   = 1'b0;
    to_cnt_d    = '0;
`ifdef PS2_BREAK_DECODE_EN
    ext_d = ext_q;
    brk_d = brk_q;
`endif

    if (state_q != ST_IDLE && !strobe) begin
      if (to_cnt_q == TO_LAST) timeout = 1'b1;
      else                     to_cnt_d = to_cnt_q + TW'(1);
    end

    if (timeout) begin
      state_d = ST_IDLE;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = dat;
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (dat && ps2_parity_ok(shift_q, parity_q)) begin
`ifdef PS2_BREAK_DECODE_EN
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
              brk_d = 1'b1;
            end else begin
              push_d      = 1'b1;
              push_data_d = {ext_q, brk_q, shift_q};
              ext_d       = 1'b0;
              brk_d       = 1'b0;
            end
`else
            push_d      = 1'b1;
            push_data_d = shift_q;
`endif
          end else begin
            frame_bad = 1'b1;
          end
        end
      endcase
    end

`ifdef PS2_BREAK_DECODE_EN
    if (timeout || frame_bad) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end
`endif

  ps2_word_t     mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_pop, do_push, drop;
  logic          overflow_q, frame_err_q;

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en && rd_valid;
  assign do_push = push_q && (!full || do_pop);
  assign drop    = push_q && full && !do_pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Sticky flags: a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (drop)           overflow_q <= 1'b1;
      else if (clear_err) overflow_q <= 1'b0;
      if (timeout || frame_bad) frame_err_q <= 1'b1;
      else if (clear_err)       frame_err_q <= 1'b0;
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo; PS2_BREAK_DECODE_EN adds the prefix-decode vectors.
// The PS/2 bit rate and timeout are scaled down so the run stays short.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int FIFO_DEPTH     = 4;
  localparam int HALF           = 50;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  ps2_clk;
  logic                  ps2_dat;
  logic                  rd_en;
  logic                  rd_valid;
  logic [PS2_DATA_W-1:0] rd_data;
  logic                  overflow;
  logic                  frame_err;
  logic                  clear_err;

  int errors = 0;
  int checks = 0;

  ps2_rx_fifo #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .overflow (overflow),
    .frame_err(frame_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Bit i of bits goes out on the i-th PS/2 clock; data changes while the clock is high.
  task automatic applyStimulus(input logic [10:0] bits, input int n, input bit popAtLast);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (popAtLast && i == n - 1) begin
        repeat (7) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        repeat (HALF - 8) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] data, input bit badParity, input bit popAtLast);
    logic par;
    par = (~^data) ^ badParity;
    applyStimulus({1'b1, par, data, 1'b0}, 11, popAtLast);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    ps2_clk   = 1'b1;
    ps2_dat   = 1'b1;
    rd_en     = 1'b0;
    clear_err = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_no_push", 32'(rd_valid), 32'h0);

    $display("[TB] valid frame 1C");
    sendFrame(8'h1C, 1'b0, 1'b0);
    checkOutput("f1c_valid", 32'(rd_valid), 32'h1);
    checkOutput("f1c_data", 32'(rd_data), 32'h1C);
    checkOutput("f1c_ferr", 32'(frame_err), 32'h0);
    popOne();
    checkOutput("f1c_pop_empty", 32'(rd_valid), 32'h0);

    $display("[TB] bad parity frame");
    sendFrame(8'h1C, 1'b1, 1'b0);
    checkOutput("par_no_push", 32'(rd_valid), 32'h0);
    checkOutput("par_ferr", 32'(frame_err), 32'h1);
    pulseClear();
    checkOutput("par_cleared", 32'(frame_err), 32'h0);

    $display("[TB] timeout after start plus 5 bits");
    applyStimulus(11'b000_0101_0010, 6, 1'b0);
    repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
    #1;
    checkOutput("to_ferr", 32'(frame_err), 32'h1);
    checkOutput("to_no_push", 32'(rd_valid), 32'h0);
    pulseClear();
    sendFrame(8'h29, 1'b0, 1'b0);
    checkOutput("to_next_valid", 32'(rd_valid), 32'h1);
    checkOutput("to_next_data", 32'(rd_data), 32'h29);
    checkOutput("to_next_ferr", 32'(frame_err), 32'h0);
    popOne();

    $display("[TB] overflow with five frames");
    for (int i = 1; i <= 4; i++) sendFrame(8'(i), 1'b0, 1'b0);
    checkOutput("full_no_ovf", 32'(overflow), 32'h0);
    sendFrame(8'h05, 1'b0, 1'b0);
    checkOutput("ovf_set", 32'(overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("ovf_pop_valid", 32'(rd_valid), 32'h1);
      checkOutput("ovf_pop_data", 32'(rd_data), 32'(i));
      popOne();
    end
    checkOutput("ovf_drained", 32'(rd_valid), 32'h0);
    pulseClear();
    checkOutput("ovf_cleared", 32'(overflow), 32'h0);

    $display("[TB] push and pop together while full");
    for (int i = 1; i <= 4; i++) sendFrame(8'h10 + 8'(i), 1'b0, 1'b0);
    sendFrame(8'h15, 1'b0, 1'b1);
    checkOutput("pp_no_ovf", 32'(overflow), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      checkOutput("pp_pop_data", 32'(rd_data), 32'h10 + 32'(i));
      popOne();
    end
    checkOutput("pp_drained", 32'(rd_valid), 32'h0);

    $display("[TB] reset mid-frame");
    sendFrame(8'h33, 1'b0, 1'b0);
    applyStimulus(11'b000_0000_1010, 5, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_emptied", 32'(rd_valid), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    sendFrame(8'h5A, 1'b0, 1'b0);
    checkOutput("rst_next_data", 32'(rd_data), 32'h5A);
    checkOutput("rst_ovf", 32'(overflow), 32'h0);
    checkOutput("rst_ferr", 32'(frame_err), 32'h0);
    popOne();
    checkOutput("rst_only_one", 32'(rd_valid), 32'h0);

`ifdef PS2_BREAK_DECODE_EN
    $display("[TB] prefix decode");
    sendFrame(8'hE0, 1'b0, 1'b0);
    checkOutput("dec_e0_held", 32'(rd_valid), 32'h0);
    sendFrame(8'hF0, 1'b0, 1'b0);
    sendFrame(8'h6B, 1'b0, 1'b0);
    checkOutput("dec_ext_brk", 32'(rd_data), 32'h36B);
    popOne();
    checkOutput("dec_single", 32'(rd_valid), 32'h0);
    sendFrame(8'hF0, 1'b0, 1'b0);
    sendFrame(8'h1C, 1'b0, 1'b0);
    checkOutput("dec_brk", 32'(rd_data), 32'h11C);
    popOne();
`else
    $display("[TB] prefix byte pushed raw");
    sendFrame(8'hF0, 1'b0, 1'b0);
    checkOutput("raw_f0_valid", 32'(rd_valid), 32'h1);
    checkOutput("raw_f0_data", 32'(rd_data), 32'hF0);
    popOne();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
